par_fifo: RTL and testbench

PAR_FIFO -- requirements
Module: par_fifo

---
 rtl/par_fifo.sv | 151 +++++++++++++++
 tb/tb_par_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/par_fifo.sv
// -----------------------------------------------------------------------------
// par_fifo -- circular-buffer FIFO with parallel (multi-element) write and read.
//
// Each accepted write pushes PAR_WRITE elements and each accepted read pops
// PAR_READ elements. Pointers are element-granular and wrap modulo MEM_SIZE,
// so a group may straddle the end of the storage array even when MEM_SIZE is
// not a multiple of the group width.
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rstn   in   asynchronous active-low reset (clears pointers and count)
//   clear  in   synchronous flush; wins over wen/ren in the same cycle
//   wen    in   write request, honoured only while ready=1
//   ren    in   read request, honoured only while valid=1
//   din    in   PAR_WRITE elements, element 0 (oldest) in the LSBs
//   dout   out  PAR_READ oldest stored elements, element 0 in the LSBs;
//               combinational, meaningful only while valid=1
//   full   out  count == MEM_SIZE
//   empty  out  count == 0
//   valid  out  at least PAR_READ elements stored
//   ready  out  room for at least PAR_WRITE more elements
// -----------------------------------------------------------------------------
module par_fifo #(
    parameter int SIZE      = 2,
    parameter int MEM_SIZE  = 4,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 3
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    input  logic                        wen,
    input  logic                        ren,
    input  logic [PAR_WRITE*SIZE-1:0]   din,
    output logic [PAR_READ*SIZE-1:0]    dout,
    output logic                        full,
    output logic                        empty,
    output logic                        valid,
    output logic                        ready
);

    localparam int ADDR_W = $clog2(MEM_SIZE);
    localparam int CNT_W  = $clog2(MEM_SIZE + 1);

    // One extra bit on pointer arithmetic so base+offset (< 2*MEM_SIZE)
    // never overflows before the modulo correction.
    localparam logic [ADDR_W:0]  MEM_EXT   = (ADDR_W+1)'(MEM_SIZE);
    localparam logic [ADDR_W:0]  WR_STEP   = (ADDR_W+1)'(PAR_WRITE);
    localparam logic [ADDR_W:0]  RD_STEP   = (ADDR_W+1)'(PAR_READ);

    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(MEM_SIZE);
    localparam logic [CNT_W-1:0] CNT_READY_MAX = CNT_W'(MEM_SIZE - PAR_WRITE);
    localparam logic [CNT_W-1:0] CNT_WR        = CNT_W'(PAR_WRITE);
    localparam logic [CNT_W-1:0] CNT_RD        = CNT_W'(PAR_READ);

    // (base + off) mod MEM_SIZE, valid for base < MEM_SIZE and off <= MEM_SIZE,
    // so a single conditional subtract is enough.
    function automatic logic [ADDR_W-1:0] wrap_add(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W:0]   off
    );
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= MEM_EXT) begin
            sum = sum - MEM_EXT;
        end
        return sum[ADDR_W-1:0];
    endfunction

    logic [SIZE-1:0]   mem [MEM_SIZE];

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] wptr_next;
    logic [ADDR_W-1:0] rptr_next;
    logic [CNT_W-1:0]  count_next;

    logic [ADDR_W-1:0] wr_idx [PAR_WRITE];
    logic [ADDR_W-1:0] rd_idx [PAR_READ];

    logic do_write;
    logic do_read;

    // Status flags are pure decodes of the registered count, so acceptance
    // depends only on pre-edge occupancy (no same-cycle bypass).
    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);
    assign valid = (count_reg >= CNT_RD);
    assign ready = (count_reg <= CNT_READY_MAX);

    assign do_write = wen && ready && !clear;
    assign do_read  = ren && valid && !clear;

    genvar gi;
    generate
        for (gi = 0; gi < PAR_WRITE; gi++) begin : g_wr_idx
            assign wr_idx[gi] = wrap_add(wptr_reg, (ADDR_W+1)'(gi));
        end
        for (gi = 0; gi < PAR_READ; gi++) begin : g_rd
            assign rd_idx[gi] = wrap_add(rptr_reg, (ADDR_W+1)'(gi));
            assign dout[gi*SIZE +: SIZE] = mem[rd_idx[gi]];
        end
    endgenerate

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        if (do_write) begin
            wptr_next = wrap_add(wptr_reg, WR_STEP);
        end
        if (do_read) begin
            rptr_next = wrap_add(rptr_reg, RD_STEP);
        end
        // Modular add/sub is safe: ready/valid guarantee no over/underflow.
        case ({do_write, do_read})
            2'b10:   count_next = count_reg + CNT_WR;
            2'b01:   count_next = count_reg - CNT_RD;
            2'b11:   count_next = count_reg + CNT_WR - CNT_RD;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else if (clear) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    // Storage is deliberately not reset; stale data is unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                mem[wr_idx[i]] <= din[i*SIZE +: SIZE];
            end
        end
    end

endmodule

// File: tb/tb_par_fifo.sv
// -----------------------------------------------------------------------------
// tb_par_fifo -- self-checking bench for par_fifo (default parameters).
// A driver issues directed then random stimulus and keeps a queue-based model
// of the stored elements; expected read groups go into a scoreboard queue that
// a separate monitor pops whenever the DUT accepts a read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_par_fifo;

    localparam int SIZE      = 2;
    localparam int MEM_SIZE  = 4;
    localparam int PAR_WRITE = 2;
    localparam int PAR_READ  = 3;

    logic                      clk;
    logic                      rstn;
    logic                      clear;
    logic                      wen;
    logic                      ren;
    logic [PAR_WRITE*SIZE-1:0] din;
    logic [PAR_READ*SIZE-1:0]  dout;
    logic                      full;
    logic                      empty;
    logic                      valid;
    logic                      ready;

    par_fifo #(
        .SIZE      (SIZE),
        .MEM_SIZE  (MEM_SIZE),
        .PAR_WRITE (PAR_WRITE),
        .PAR_READ  (PAR_READ)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .wen   (wen),
        .ren   (ren),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .valid (valid),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [SIZE-1:0]          model_q [$];
    logic [PAR_READ*SIZE-1:0] exp_q   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".full"},  {31'd0, full},  {31'd0, n == MEM_SIZE});
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, n == 0});
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, n >= PAR_READ});
        check({tag, ".ready"}, {31'd0, ready}, {31'd0, (MEM_SIZE - n) >= PAR_WRITE});
    endtask

    // One clock of stimulus: check flags for current state, drive inputs,
    // advance the model to the post-edge state.
    task automatic step(input logic w, input logic r, input logic c,
                        input logic [PAR_WRITE*SIZE-1:0] d, input string tag);
        int  n;
        bit  acc_w;
        bit  acc_r;
        logic [PAR_READ*SIZE-1:0] e;
        @(negedge clk);
        #1;
        check_flags(tag);
        wen = w; ren = r; clear = c; din = d;
        n = model_q.size();
        acc_w = w && !c && ((MEM_SIZE - n) >= PAR_WRITE);
        acc_r = r && !c && (n >= PAR_READ);
        $display("step %-10s wen=%0d ren=%0d clr=%0d din=%0d cnt=%0d wr=%0d rd=%0d",
                 tag, w, r, c, d, n, acc_w, acc_r);
        if (c) begin
            model_q.delete();
        end else begin
            if (acc_r) begin
                e = '0;
                for (int k = 0; k < PAR_READ; k++) begin
                    e[k*SIZE +: SIZE] = model_q[k];
                end
                exp_q.push_back(e);
                for (int k = 0; k < PAR_READ; k++) begin
                    void'(model_q.pop_front());
                end
            end
            if (acc_w) begin
                for (int k = 0; k < PAR_WRITE; k++) begin
                    model_q.push_back(d[k*SIZE +: SIZE]);
                end
            end
        end
    endtask

    // Drop rstn between edges while a write is being requested; flags must
    // return to reset values before the next rising edge.
    task automatic async_reset(input string tag);
        #4;
        wen = 1'b1;
        rstn = 1'b0;
        #1;
        check({tag, ".empty"}, {31'd0, empty}, 32'd1);
        check({tag, ".full"},  {31'd0, full},  32'd0);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".ready"}, {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".held_empty"}, {31'd0, empty}, 32'd1);
        wen = 1'b0; ren = 1'b0; clear = 1'b0;
        rstn = 1'b1;
        model_q.delete();
        $display("async reset %s", tag);
    endtask

    // Monitor: compare dout whenever the DUT accepts a read.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rstn && ren && valid && !clear) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: got dout=%0d expected no read", dout);
                end else begin
                    logic [PAR_READ*SIZE-1:0] e;
                    e = exp_q.pop_front();
                    check("read_dout", {26'd0, dout}, {26'd0, e});
                    $display("read dout=%0d exp=%0d", dout, e);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Reset state, partial fill, fill, ignored write on full
        step(1'b1, 1'b0, 1'b0, 4'b0101, "fill1");
        step(1'b1, 1'b0, 1'b0, 4'd7,    "fill2");
        step(1'b1, 1'b0, 1'b0, 4'd10,   "wr_full");
        check("dout_full", {26'd0, dout}, 32'd53);
        check("full_set",  {31'd0, full}, 32'd1);
        // Read, then a write that wraps to locations 0 and 1
        step(1'b0, 1'b1, 1'b0, 4'd0,    "read1");
        step(1'b1, 1'b0, 1'b0, 4'd7,    "wrap_wr");
        step(1'b0, 1'b0, 1'b0, 4'd0,    "idle");
        check("dout_wrap", {26'd0, dout}, 32'd29);
        // count=3: write refused (ready=0), read accepted -> count 0
        step(1'b1, 1'b1, 1'b0, 4'd9,    "simul");
        step(1'b0, 1'b0, 1'b0, 4'd0,    "after_sim");
        check("sim_empty", {31'd0, empty}, 32'd1);
        // Clear beats a concurrent write
        step(1'b1, 1'b0, 1'b0, 4'd3,    "pre_clr");
        step(1'b1, 1'b1, 1'b1, 4'd5,    "clear");
        step(1'b0, 1'b0, 1'b0, 4'd0,    "after_clr");
        check("clr_empty", {31'd0, empty}, 32'd1);
        // Async reset in the middle of a write sequence
        step(1'b1, 1'b0, 1'b0, 4'd6,    "pre_rst");
        async_reset("rst_mid");
        step(1'b0, 1'b0, 1'b0, 4'd0,    "after_rst");

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            logic w, r, c;
            logic [PAR_WRITE*SIZE-1:0] d;
            w = ($urandom_range(99) < 60);
            r = ($urandom_range(99) < 55);
            c = ($urandom_range(99) < 3);
            d = PAR_WRITE*SIZE'($urandom);
            step(w, r, c, d, "rand");
            if (i == 700) begin
                async_reset("rst_rand");
            end
        end

        step(1'b0, 1'b0, 1'b0, 4'd0, "drain");
        @(negedge clk);
        #5;
        check("scoreboard_left", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
